// File: rtl/audio_sdm2_out_if.sv
// Sample input bus for audio_sdm2_out.
//   in_data  : {R, L} signed samples, L in [WIDTH-1:0]
//   in_valid : single-cycle sample strobe
//   in_ready : sink ready (constant 1 once out of reset)
// master = sample producer, slave = output stage.
interface audio_sdm2_out_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [2*WIDTH-1:0] in_data;
  logic               in_valid;
  logic               in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/audio_sdm2_out.sv
// Stereo audio output stage: soft mute/unmute gain ramp followed by a
// second-order delta-sigma modulator per channel, driving two 1-bit pins.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_if      : sample bus (slave) -- in_data {R, L}, in_valid, in_ready
//   enable     : 1 = play (ramp gain up), 0 = mute (ramp gain down)
//   muted      : 1 while the ramp sits in the muted state
//   gain       : current gain, unity = 2^GAIN_BITS
//   pdm        : registered 1-bit streams {R, L}
//
// Optional build macro AUDIO_SDM2_DITHER_EN: adds a 16-bit LFSR whose bit 0
// (as +/-1, inverted for R) is added to the quantiser decision input.
module audio_sdm2_out #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned GAIN_BITS = 8,
  parameter int unsigned INT_GUARD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  audio_sdm2_out_if.slave        in_if,
  input  logic                   enable,
  output logic                   muted,
  output logic [GAIN_BITS:0]     gain,
  output logic [1:0]             pdm
);

  localparam int unsigned IW = WIDTH + INT_GUARD;       // integrator width
  localparam int unsigned SW = IW + 2;                  // headroom for sums
  localparam int unsigned PW = WIDTH + GAIN_BITS + 2;   // sample x gain product

  localparam logic [GAIN_BITS:0] Unity = {1'b1, {GAIN_BITS{1'b0}}};

  localparam logic signed [SW-1:0] IntMax = SW'(2 ** (IW - 2));
  localparam logic signed [SW-1:0] IntMin = -IntMax;
  localparam logic signed [SW-1:0] FbPos  = SW'(2 ** (WIDTH - 1));
  localparam logic signed [PW-1:0] SmpMax = PW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [PW-1:0] SmpMin = -SmpMax - PW'(1);

  typedef enum logic [1:0] {StMuted, StRampUp, StPlay, StRampDown} state_e;

  state_e                   state_q, state_d;
  logic [GAIN_BITS:0]       gain_q, gain_d;
  logic [2*WIDTH-1:0]       sample_q;
  logic [1:0][WIDTH-1:0]    scaled_q, scaled_d;
  logic [1:0][IW-1:0]       i1_q, i1_d, i2_q, i2_d;
  logic [1:0]               pdm_q, pdm_d;
  logic                     in_ready_q;
`ifdef AUDIO_SDM2_DITHER_EN
  logic [15:0]              lfsr_q, lfsr_d;
`endif

  // (sample * gain) >>> GAIN_BITS, floor rounding, clamped to the sample range.
  function automatic logic [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] s,
                                             input logic [GAIN_BITS:0] g);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    prod    = s * $signed({1'b0, g});
    shifted = prod >>> GAIN_BITS;
    if (shifted > SmpMax) return SmpMax[WIDTH-1:0];
    if (shifted < SmpMin) return SmpMin[WIDTH-1:0];
    return shifted[WIDTH-1:0];
  endfunction

  function automatic logic [IW-1:0] sat_int(input logic signed [SW-1:0] v);
    if (v > IntMax) return IntMax[IW-1:0];
    if (v < IntMin) return IntMin[IW-1:0];
    return v[IW-1:0];
  endfunction

  always_comb begin
    scaled_d = '0;
    for (int c = 0; c < 2; c++) begin
      scaled_d[c] = scale($signed(sample_q[c*WIDTH +: WIDTH]), gain_q);
    end
  end

  // Both integrators and the decision use the previous-cycle state.
  always_comb begin
    logic signed [SW-1:0] fb;
    logic signed [SW-1:0] dec;
`ifdef AUDIO_SDM2_DITHER_EN
    logic signed [SW-1:0] dith;
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
    i1_d  = '0;
    i2_d  = '0;
    pdm_d = '0;
    for (int c = 0; c < 2; c++) begin
      fb      = pdm_q[c] ? FbPos : -FbPos;
      i1_d[c] = sat_int(SW'($signed(i1_q[c])) + SW'($signed(scaled_q[c])) - fb);
      i2_d[c] = sat_int(SW'($signed(i2_q[c])) + SW'($signed(i1_q[c])) - fb);
`ifdef AUDIO_SDM2_DITHER_EN
      dith    = (lfsr_q[0] ^ (c == 1)) ? SW'(1) : -SW'(1);
      dec     = SW'($signed(i2_q[c])) + dith;
`else
      dec     = SW'($signed(i2_q[c]));
`endif
      pdm_d[c] = (dec >= 0);
    end
  end

  // Gain moves one step per accepted sample; an enable change takes priority
  // over the step in the same cycle. Endpoint checks keep gain in range even
  // when the direction flips right at 0 or unity.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    unique case (state_q)
      StMuted: begin
        if (enable) state_d = StRampUp;
      end
      StRampUp: begin
        if (!enable) begin
          state_d = StRampDown;
        end else if (gain_q == Unity) begin
          state_d = StPlay;
        end else if (in_if.in_valid) begin
          gain_d = gain_q + 1'b1;
          if (gain_q == Unity - 1'b1) state_d = StPlay;
        end
      end
      StPlay: begin
        if (!enable) state_d = StRampDown;
      end
      StRampDown: begin
        if (enable) begin
          state_d = StRampUp;
        end else if (gain_q == '0) begin
          state_d = StMuted;
        end else if (in_if.in_valid) begin
          gain_d = gain_q - 1'b1;
          if (gain_q == (GAIN_BITS+1)'(1)) state_d = StMuted;
        end
      end
      default: state_d = StMuted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StMuted;
      gain_q     <= '0;
      sample_q   <= '0;
      scaled_q   <= '0;
      i1_q       <= '0;
      i2_q       <= '0;
      pdm_q      <= '0;
      in_ready_q <= 1'b0;
`ifdef AUDIO_SDM2_DITHER_EN
      lfsr_q     <= 16'hACE1;
`endif
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      if (in_if.in_valid) sample_q <= in_if.in_data;
      scaled_q   <= scaled_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      pdm_q      <= pdm_d;
      in_ready_q <= 1'b1;
`ifdef AUDIO_SDM2_DITHER_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign muted          = (state_q == StMuted);
  assign gain           = gain_q;
  assign pdm            = pdm_q;

endmodule

// File: tb/tb_audio_sdm2_out.sv
module tb_audio_sdm2_out;
  localparam int WIDTH     = 16;
  localparam int GAIN_BITS = 8;
  localparam int INT_GUARD = 4;
  localparam int UNITY     = 1 << GAIN_BITS;
  localparam int HALF      = 1 << (WIDTH - 1);
  localparam int ILIM      = 1 << (WIDTH + INT_GUARD - 2);
`ifdef AUDIO_SDM2_DITHER_EN
  localparam bit DITHER = 1'b1;
  localparam int IDLE_TOL = 20;
`else
  localparam bit DITHER = 1'b0;
  localparam int IDLE_TOL = 2;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 muted;
  logic [GAIN_BITS:0]   gain;
  logic [1:0]           pdm;

  audio_sdm2_out_if #(.WIDTH(WIDTH)) bus ();

  audio_sdm2_out #(
    .WIDTH(WIDTH), .GAIN_BITS(GAIN_BITS), .INT_GUARD(INT_GUARD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_if(bus), .enable(enable),
    .muted(muted), .gain(gain), .pdm(pdm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int ones_l, ones_r;

  task automatic check(input string tag, input longint obs, input longint lo, input longint hi);
    n_checks++;
    if (obs < lo || obs > hi) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d..%0d at %0t", tag, obs, lo, hi, $time);
    end
  endtask

  // Reference model: plain integer arithmetic straight from the block's rules.
  int       m_smp[2], m_scl[2], m_i1[2], m_i2[2], m_pdm[2];
  int       m_gain;   // 0 .. UNITY
  int       m_mode;   // 0 muted, 1 ramp up, 2 play, 3 ramp down
  int       m_ready;
  bit [15:0] m_lfsr;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_smp[c] = 0; m_scl[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_pdm[c] = 0;
    end
    m_gain = 0; m_mode = 0; m_ready = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input bit v, input logic [31:0] data, input bit en);
    int ns[2], nscl[2], ni1[2], ni2[2], np[2];
    int y, d;
    logic [15:0] half_word;
    for (int c = 0; c < 2; c++) begin
      half_word = data[c*16 +: 16];
      ns[c]   = v ? int'($signed(half_word)) : m_smp[c];
      nscl[c] = clamp((m_smp[c] * m_gain) >>> GAIN_BITS, -HALF, HALF - 1);
      y       = m_pdm[c] ? HALF : -HALF;
      ni1[c]  = clamp(m_i1[c] + m_scl[c] - y, -ILIM, ILIM);
      ni2[c]  = clamp(m_i2[c] + m_i1[c] - y, -ILIM, ILIM);
      d       = DITHER ? (((m_lfsr[0] ^ (c == 1)) != 0) ? 1 : -1) : 0;
      np[c]   = (m_i2[c] + d >= 0) ? 1 : 0;
    end
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (!en) m_mode = 3;
        else if (m_gain == UNITY) m_mode = 2;
        else if (v) begin
          m_gain++;
          if (m_gain == UNITY) m_mode = 2;
        end
      end
      2: if (!en) m_mode = 3;
      default: begin
        if (en) m_mode = 1;
        else if (m_gain == 0) m_mode = 0;
        else if (v) begin
          m_gain--;
          if (m_gain == 0) m_mode = 0;
        end
      end
    endcase
    for (int c = 0; c < 2; c++) begin
      m_smp[c] = ns[c]; m_scl[c] = nscl[c]; m_i1[c] = ni1[c]; m_i2[c] = ni2[c];
      m_pdm[c] = np[c];
    end
    m_ready = 1;
  endtask

  // One clock: present inputs, step the model at the edge, compare 1 ns later.
  task automatic clk_cycle(input bit v, input logic [31:0] data);
    bus.in_valid = v;
    bus.in_data  = data;
    @(posedge clk);
    model_step(v, data, enable);
    #1;
    check("pdm", pdm, m_pdm[1] * 2 + m_pdm[0], m_pdm[1] * 2 + m_pdm[0]);
    check("gain", gain, m_gain, m_gain);
    check("muted", muted, (m_mode == 0) ? 1 : 0, (m_mode == 0) ? 1 : 0);
    check("in_ready", bus.in_ready, m_ready, m_ready);
    ones_l += pdm[0];
    ones_r += pdm[1];
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_cycle(1'b0, $urandom());
  endtask

  // Strobe a sample after a random gap of idle clocks.
  task automatic strobe(input logic [31:0] data);
    idle($urandom_range(0, 3));
    clk_cycle(1'b1, data);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();

    // Reset state.
    #12;
    check("rst_pdm", pdm, 0, 0);
    check("rst_gain", gain, 0, 0);
    check("rst_muted", muted, 1, 1);
    check("rst_in_ready", bus.in_ready, 0, 0);
    #11 rst_n = 1'b1;

    // Idle muted: zero input gives a 50 % duty limit cycle.
    ones_l = 0; ones_r = 0;
    for (int i = 0; i < 4096; i++) clk_cycle(1'b0, '0);
    check("idle_ones_l", ones_l, 2048 - IDLE_TOL, 2048 + IDLE_TOL);
    check("idle_ones_r", ones_r, 2048 - IDLE_TOL, 2048 + IDLE_TOL);
    check("idle_gain", gain, 0, 0);
    check("idle_muted", muted, 1, 1);

    // Ramp up with half-scale input.
    enable = 1'b1;
    idle(2);
    for (int k = 1; k <= UNITY; k++) begin
      strobe(32'h4000_4000);
      check("ramp_up_gain", gain, k, k);
      if (k == 1) check("ramp_up_unmuted", muted, 0, 0);
    end
    idle(64);
    ones_l = 0; ones_r = 0;
    idle(8192);
    check("half_ones_l", ones_l, 6144 - 16, 6144 + 16);
    check("half_ones_r", ones_r, 6144 - 16, 6144 + 16);

    // Full-scale positive on L, most-negative on R (scale clamp edge).
    clk_cycle(1'b1, 32'h8000_7FFF);
    idle(4);
    ones_l = 0; ones_r = 0;
    idle(8192);
    check("full_ones_l", ones_l, 8180, 8192);
    check("full_ones_r", ones_r, 0, 12);

    // Ramp all the way down, then up to 100 and abort with a coincident strobe.
    enable = 1'b0;
    idle(1);
    for (int k = UNITY - 1; k >= 0; k--) begin
      strobe($urandom());
      check("ramp_down_gain", gain, k, k);
    end
    check("ramp_down_muted", muted, 1, 1);
    enable = 1'b1;
    idle(1);
    for (int k = 1; k <= 100; k++) strobe($urandom());
    check("abort_pre_gain", gain, 100, 100);
    enable = 1'b0;
    clk_cycle(1'b1, $urandom());
    check("abort_gain_held", gain, 100, 100);
    check("abort_not_muted", muted, 0, 0);
    for (int k = 99; k >= 0; k--) begin
      strobe($urandom());
      check("abort_down_gain", gain, k, k);
    end
    check("abort_muted", muted, 1, 1);

    // Asynchronous reset mid-ramp.
    enable = 1'b1;
    idle(1);
    for (int k = 0; k < 50; k++) strobe(32'h2000_E000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pdm", pdm, 0, 0);
    check("arst_gain", gain, 0, 0);
    check("arst_muted", muted, 1, 1);
    check("arst_in_ready", bus.in_ready, 0, 0);
    model_reset();
    #3 rst_n = 1'b1;
    clk_cycle(1'b0, '0);
    check("arst_in_ready_back", bus.in_ready, 1, 1);

    // Random traffic with random enable flips.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      clk_cycle(($urandom_range(0, 1) == 1), $urandom());
    end

`ifdef AUDIO_SDM2_DITHER_EN
    // Silence in PLAY with dither.
    enable = 1'b1;
    for (int k = 0; k < UNITY + 2; k++) clk_cycle(1'b1, '0);
    idle(8);
    ones_l = 0; ones_r = 0;
    idle(65535);
    check("dither_ones_l", ones_l, 32768 - 328, 32767 + 328);
    check("dither_ones_r", ones_r, 32768 - 328, 32767 + 328);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
